// File: rtl/v850_fetch_queue.sv
// v850_fetch_queue: V850 instruction fetch unit with a halfword prefetch queue.
// Issues aligned 32-bit reads, buffers halfwords, and hands 16/32-bit
// instructions with their PC to decode through a valid/ready handshake.
// Optional feature: define V850_FETCH_PERF_EN to add the perf_stall_cnt port
// and its 32-bit decode-stall counter.
module v850_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QUEUE_HW = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_len32
`ifdef V850_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int PW = $clog2(QUEUE_HW);
    localparam int CW = PW + 1;
    // A request may issue only if at least two halfword slots are free.
    localparam logic [CW-1:0] ISSUE_MAX = CW'(QUEUE_HW - 2);

    logic [15:0]   queue_q [QUEUE_HW];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   req_addr_q;
    logic          skip_hw_q, skip_hw_d;
    logic          drop_q, drop_d;
    logic          busy_q, busy_d;

    logic [15:0]   head_hw, second_hw;
    logic          head_is32;
    logic          pop_fire, issue, ack_fire, push_en;
    logic [CW-1:0] pop_n, push_n, avail;

    assign head_hw   = queue_q[head_q];
    assign second_hw = queue_q[head_q + PW'(1)];
    assign head_is32 = (head_hw[10:9] == 2'b11);

    // A 32-bit instruction whose second halfword has not arrived yet is held back.
    assign inst_valid = !redirect_valid &&
                        ((count_q >= CW'(2)) || ((count_q == CW'(1)) && !head_is32));
    assign inst       = inst_valid ? {(head_is32 ? second_hw : 16'h0000), head_hw} : 32'h0;
    assign inst_len32 = inst_valid && head_is32;
    assign inst_pc    = dec_pc_q;

    assign pop_fire = inst_valid && inst_ready;
    assign pop_n    = !pop_fire ? '0 : (head_is32 ? CW'(2) : CW'(1));
    assign avail    = count_q - pop_n;

    // Free space is judged after this cycle's pop so zero-wait memory keeps pace with decode.
    assign issue     = !busy_q && !redirect_valid && (avail <= ISSUE_MAX);
    assign imem_req  = !rst && (busy_q || issue);
    // The address of an outstanding request is frozen even if a redirect moves fetch_addr.
    assign imem_addr = busy_q ? req_addr_q : fetch_addr_q;
    assign ack_fire  = imem_req && imem_ack;
    assign push_en   = ack_fire && !drop_q && !redirect_valid;
    assign push_n    = !push_en ? '0 : (skip_hw_q ? CW'(1) : CW'(2));

    // Next-state: net push/pop bookkeeping, with redirect overriding everything.
    always_comb begin
        head_d       = head_q + pop_n[PW-1:0];
        tail_d       = tail_q + push_n[PW-1:0];
        count_d      = count_q - pop_n + push_n;
        dec_pc_d     = dec_pc_q + {{(32-CW-1){1'b0}}, pop_n, 1'b0};
        fetch_addr_d = fetch_addr_q;
        skip_hw_d    = skip_hw_q;
        drop_d       = drop_q;
        busy_d       = imem_req && !imem_ack;
        if (ack_fire) begin
            drop_d = 1'b0;
            if (!drop_q) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_hw_d    = 1'b0;
            end
        end
        if (redirect_valid) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            dec_pc_d     = redirect_pc & ~32'd1;
            fetch_addr_d = redirect_pc & ~32'd3;
            skip_hw_d    = redirect_pc[1];
            // A request still in flight completes on the bus but its data is discarded.
            drop_d       = imem_req && !imem_ack;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dec_pc_q     <= RESET_PC & ~32'd1;
            fetch_addr_q <= RESET_PC & ~32'd3;
            req_addr_q   <= RESET_PC & ~32'd3;
            skip_hw_q    <= RESET_PC[1];
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            dec_pc_q     <= dec_pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= imem_addr;
            skip_hw_q    <= skip_hw_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
        end
    end

    // Queue storage: write one or two halfwords at the tail on an accepted response.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (skip_hw_q) begin
                queue_q[tail_q] <= imem_rdata[31:16];
            end else begin
                queue_q[tail_q]          <= imem_rdata[15:0];
                queue_q[tail_q + PW'(1)] <= imem_rdata[31:16];
            end
        end
    end

`ifdef V850_FETCH_PERF_EN
    logic [31:0] perf_q;

    // Count cycles where decode is ready but has nothing to take.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (inst_ready && !inst_valid && !redirect_valid) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_v850_fetch_queue.sv
// Testbench for v850_fetch_queue: table-driven cycle vectors plus directed
// sequences for redirect-while-pending, backpressure and the stall counter.
module tb_v850_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, redirect_valid, inst_valid, inst_ready, inst_len32;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
`ifdef V850_FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    v850_fetch_queue #(.RESET_PC(32'h0000_0000), .QUEUE_HW(8)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_len32(inst_len32)
`ifdef V850_FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Memory model: word array with a programmable number of wait states.
    logic [31:0] mem [0:255];
    int          wait_states = 0;
    logic [7:0]  wcnt = 8'd0;
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 8'd0;
        else                       wcnt <= wcnt + 8'd1;
    end
    assign imem_ack   = imem_req && (int'(wcnt) >= wait_states);
    assign imem_rdata = mem[imem_addr[9:2]];

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_len;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        len;
    } exp_t;

    vec_t vecs [14];
    exp_t drain_exp [9];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] ins, input logic [31:0] pc, input logic len);
        vec_t t;
        t.ready = rdy; t.rv = rv; t.rpc = rpc; t.e_req = req; t.e_addr = addr;
        t.e_valid = v; t.e_inst = ins; t.e_pc = pc; t.e_len = len;
        return t;
    endfunction

    function automatic exp_t mke(input logic [31:0] pc, input logic [31:0] ins, input logic len);
        exp_t t;
        t.pc = pc; t.ins = ins; t.len = len;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ack20_cyc, req40_cyc, got, acks, pushed, viol, addr_err, k;
        logic [31:0] first_inst, first_pc;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0001_0000;   // 0x00: two 16-bit
        mem[1]  = 32'h0640_0002;   // 0x04: 16-bit, then 32-bit head at 0x06
        mem[2]  = 32'h0003_1234;   // 0x08: tail of 32-bit, 16-bit
        mem[3]  = 32'h0005_0004;   // 0x0C
        mem[8]  = 32'h0021_0020;   // 0x20: must never reach decode
        mem[16] = 32'h0041_0040;   // 0x40
        mem[32] = 32'h0101_0100;   // 0x80
        mem[33] = 32'hBEEF_0660;   // 0x84: 32-bit instruction
        mem[34] = 32'h0103_0102;
        mem[35] = 32'h0105_0104;
        mem[36] = 32'h0107_0106;
        mem[64] = 32'h00AA_00BB;   // 0x100: lower halfword skipped on redirect to 0x102
        mem[65] = 32'h00CC_00DD;

        //            rdy  rv   rpc           req  addr          v    inst           pc            len
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h000, 1'b0, 32'h0,         32'h000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h004, 1'b1, 32'h0,         32'h000, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h008, 1'b1, 32'h1,         32'h002, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h00C, 1'b1, 32'h2,         32'h004, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h010, 1'b1, 32'h1234_0640, 32'h006, 1'b1);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h014, 1'b1, 32'h3,         32'h00A, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h018, 1'b1, 32'h4,         32'h00C, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h01C, 1'b1, 32'h5,         32'h00E, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,      1'b0, 32'h020, 1'b1, 32'h0,         32'h010, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h020, 1'b1, 32'h0,         32'h012, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 32'h102,    1'b0, 32'h024, 1'b0, 32'h0,         32'h014, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h100, 1'b0, 32'h0,         32'h102, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h104, 1'b1, 32'hAA,        32'h102, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,      1'b1, 32'h108, 1'b1, 32'hDD,        32'h104, 1'b0);

        drain_exp[0] = mke(32'h80, 32'h0000_0100, 1'b0);
        drain_exp[1] = mke(32'h82, 32'h0000_0101, 1'b0);
        drain_exp[2] = mke(32'h84, 32'hBEEF_0660, 1'b1);
        drain_exp[3] = mke(32'h88, 32'h0000_0102, 1'b0);
        drain_exp[4] = mke(32'h8A, 32'h0000_0103, 1'b0);
        drain_exp[5] = mke(32'h8C, 32'h0000_0104, 1'b0);
        drain_exp[6] = mke(32'h8E, 32'h0000_0105, 1'b0);
        drain_exp[7] = mke(32'h90, 32'h0000_0106, 1'b0);
        drain_exp[8] = mke(32'h92, 32'h0000_0107, 1'b0);

        // Reset state
        rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   imem_req,   1'b0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc",    inst_pc,    32'h0);
        check("rst_inst",  {inst, inst_len32}, 33'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cycle-by-cycle vectors from reset release, zero-wait memory
        for (int i = 0; i < 14; i++) begin
            inst_ready     = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {imem_req, imem_addr, inst_valid, inst, inst_pc, inst_len32},
                  {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_inst,
                   vecs[i].e_pc, vecs[i].e_len});
            @(posedge clk); #1;
        end

        // Redirect while a 3-wait-state request to 0x20 is outstanding
        wait_states = 3; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        check("redir20_cycle", {imem_req, inst_valid}, 2'b00);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("req20", {imem_req, imem_addr}, {1'b1, 32'h20});
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        check("redir40_hold", {imem_req, imem_addr, inst_valid}, {1'b1, 32'h20, 1'b0});
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ack20_cyc = -1; req40_cyc = -1; got = 0; first_inst = 32'h0; first_pc = 32'h0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (imem_req && imem_ack && imem_addr == 32'h20 && ack20_cyc < 0) ack20_cyc = c;
            if (imem_req && imem_addr == 32'h40 && req40_cyc < 0) req40_cyc = c;
            if (inst_valid) begin
                got = 1; first_inst = inst; first_pc = inst_pc;
            end
            @(posedge clk); #1;
        end
        check("ack20_cycle", ack20_cyc, 1);
        check("req40_cycle", req40_cyc, 2);
        check("redir40_first", {got[0], first_pc, first_inst}, {1'b1, 32'h40, 32'h40});

        // Backpressure: decode stalls for 20 cycles after a redirect to 0x80
        wait_states = 0; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        acks = 0; pushed = 0; viol = 0; addr_err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pushed > 6 && imem_req) viol++;
            if (imem_req && imem_ack) begin
                if (imem_addr != 32'h80 + 32'(4 * acks)) addr_err++;
                acks++;
                pushed += 2;
            end
            @(posedge clk); #1;
        end
        check("stall_acks",     acks,     4);
        check("stall_req_low",  viol,     0);
        check("stall_addr_seq", addr_err, 0);
        inst_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 9; c++) begin
            @(negedge clk);
            if (inst_valid) begin
                check($sformatf("drain%0d", k), {inst_pc, inst, inst_len32},
                      {drain_exp[k].pc, drain_exp[k].ins, drain_exp[k].len});
                k++;
            end
            @(posedge clk); #1;
        end
        check("drain_count", k, 9);

`ifdef V850_FETCH_PERF_EN
        // Stall counter: 5 ready cycles while the first fetch waits on memory
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; wait_states = 6;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; inst_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        inst_ready = 1'b0;
        @(negedge clk);
        check("perf5", perf_stall_cnt, 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        check("perf_hold", perf_stall_cnt, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/v850_fetch_queue.md
# v850_fetch_queue

Instruction fetch and prefetch queue for the V850 core. The block issues aligned 32-bit reads to instruction memory and buffers the returned halfwords in a small queue. It delimits each 16-bit or 32-bit V850 instruction and presents it, with its PC, to the decode stage through a valid/ready handshake. Control-flow redirects from execute flush the queue and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bit 0 ignored.
- QUEUE_HW, 8: queue depth in halfwords; power of two, ≥4.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request; held until imem_ack.
- imem_addr  out  32  word-aligned read address (bits [1:0]=0); stable while imem_req=1.
- imem_ack  in  1  response valid; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  read data; [15:0] is the lower-address halfword.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bit 0 ignored.
- inst_valid  out  1  inst/inst_pc/inst_len32 valid.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  instruction; [15:0] first halfword, [31:16] second halfword (zero for 16-bit).
- inst_pc  out  32  address of the instruction's first halfword; bit 0 always 0.
- inst_len32  out  1  1 = 32-bit instruction.
- perf_stall_cnt  out  32  present only with V850_FETCH_PERF_EN.

## Operation
- Length rule: the head halfword is 32-bit iff bits [10:9]=2'b11; otherwise it is 16-bit.
- Queue holds `count` halfwords (0..QUEUE_HW) in a circular buffer with head/tail pointers that wrap modulo QUEUE_HW.
- inst_valid = !redirect_valid && (count≥2 || (count==1 && head is 16-bit)). A 32-bit instruction split across two fetch words waits for the second word.
- inst, inst_pc and inst_len32 are combinational from the queue head and the decode PC register.
- Transfer on inst_valid && inst_ready: pop 1 or 2 halfwords; decode PC += 2 or 4, wrapping at 32 bits.
- Request issue: imem_req rises when no request is outstanding and (QUEUE_HW − count) ≥ 2, counted after this cycle's pop. fetch_addr += 4 on each ack.
- On ack: write both halfwords, or only [31:16] when skip_hw=1, then clear skip_hw. Push and pop in the same cycle are legal, and count updates by the net amount.
- Redirect has priority over push and pop:
  - count←0, head/tail←0.
  - decode PC←{redirect_pc[31:1],1'b0}.
  - fetch_addr←{redirect_pc[31:2],2'b00}.
  - skip_hw←redirect_pc[1].
- Redirect while a request is outstanding (including in its ack cycle): the bus request completes normally, but drop=1 discards its data. The new request issues on the cycle after that ack.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC&~3, count=0.
  - inst_valid=0, inst_pc=RESET_PC&~1, inst=0, inst_len32=0.
  - skip_hw=RESET_PC[1], drop=0, perf_stall_cnt=0.
- Reset mid-request abandons it without waiting for ack. The memory side must tolerate this.

## Timing
- imem_req asserts in the first cycle after rst deasserts.
- Zero-wait memory (ack in the request cycle): data is written at that edge, and inst_valid rises the next cycle. Reset-to-first-instruction is 2 cycles.
- Sustained throughput is one instruction per cycle for any mix, given zero-wait memory and QUEUE_HW≥4.
- Redirect at cycle N:
  - inst_valid=0 at N.
  - imem_req at N+1 if no request is outstanding.
  - First new instruction valid at N+2 with zero-wait memory.
- Full queue (count>QUEUE_HW−2): no request issues. Queue overflow is impossible by construction.

## Configuration
- V850_FETCH_PERF_EN defined: the perf_stall_cnt port and a 32-bit counter exist.
  - Increments each cycle with inst_ready=1 && inst_valid=0 && !redirect_valid.
  - Wraps at 2^32. Cleared by rst only.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=0, zero-wait memory, word 0 = 0x0001_0000 (two 16-bit instructions), inst_ready=1 → inst 0x0000_0000 pc 0x0, then 0x0000_0001 pc 0x2, on consecutive cycles.
- 32-bit straddle: word 0 = {16'h0640, 16'h0000}, word 1 = 16'h1234 in [15:0] → inst=0x1234_0640, len32=1, pc=0x2; next pc=0x6.
- Redirect to 0x0000_0102 → imem_addr=0x100; lower halfword dropped; first inst_pc=0x102.
- Redirect while a 3-wait-state request to 0x20 is pending → that response is discarded. Next request is 0x40 for redirect_pc 0x40, and no instruction from 0x20 appears.
- inst_ready=0 for 20 cycles with QUEUE_HW=8 → count never exceeds 8, imem_req stays low once count>6, and no data is lost after release.
- With V850_FETCH_PERF_EN: 5 cycles of inst_ready=1 while waiting on memory → perf_stall_cnt=5.
